// File: rtl/uart_frame_ctrl_if.sv
// Byte-stream input and register-write output bundle for uart_frame_ctrl.
// slave  : the frame controller (consumes bytes, drives the write port)
// master : the environment (drives bytes, observes the write port)
interface uart_frame_ctrl_if;
  logic       rcv;
  logic [7:0] rx_data;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       frame_err;
  logic       busy;

  modport slave (
    input  rcv,
    input  rx_data,
    output wr_en,
    output wr_addr,
    output wr_data,
    output frame_err,
    output busy
  );

  modport master (
    output rcv,
    output rx_data,
    input  wr_en,
    input  wr_addr,
    input  wr_data,
    input  frame_err,
    input  busy
  );
endinterface

// File: rtl/uart_frame_ctrl.sv
// uart_frame_ctrl: turns the receiver byte stream into register writes.
// Frame: SYNC, ADDR, DATA[, CHK]. A good frame gives a 1-cycle wr_en one
// clock after its last byte. Stalled frames are dropped by an inter-byte
// timeout that pulses frame_err.
// Optional feature macro: FRAME_CHK_EN (adds the CHK byte, checksum =
// (ADDR + DATA) mod 256; a mismatch pulses frame_err and suppresses the write).
// Reset rstn is synchronous, active-low; all outputs are registered.
module uart_frame_ctrl #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 12000
) (
  input  logic             clk,
  input  logic             rstn,
  uart_frame_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  // Last count value of a stalled frame; a silent cycle here aborts it.
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 32'sd1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_DATA  = 3'd2,
    ST_WRITE = 3'd3
`ifdef FRAME_CHK_EN
    ,
    ST_CHK   = 3'd4
`endif
  } state_t;

`ifdef FRAME_CHK_EN
  // Frame checksum: 8-bit wrap-around sum, carry discarded.
  function automatic logic [7:0] frame_sum(input logic [7:0] a, input logic [7:0] d);
    return a + d;
  endfunction
`endif

  state_t           state_r;
  logic [CNT_W-1:0] tmo_cnt_r;
  logic [7:0]       addr_r;
`ifdef FRAME_CHK_EN
  logic [7:0]       data_r;
`endif
  logic             wr_en_r;
  logic [7:0]       wr_addr_r;
  logic [7:0]       wr_data_r;
  logic             frame_err_r;
  logic             busy_r;

  logic             is_sync_s;
  logic             tmo_hit_s;

  // A byte arriving on the expiry cycle wins over the timeout.
  assign is_sync_s = bus.rcv && (bus.rx_data == SYNC_BYTE);
  assign tmo_hit_s = !bus.rcv && (tmo_cnt_r == TMO_LAST);

  // Frame sequencer with registered write/error/busy outputs and timeout counter.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r     <= ST_IDLE;
      tmo_cnt_r   <= CNT_ZERO;
      addr_r      <= 8'h00;
`ifdef FRAME_CHK_EN
      data_r      <= 8'h00;
`endif
      wr_en_r     <= 1'b0;
      wr_addr_r   <= 8'h00;
      wr_data_r   <= 8'h00;
      frame_err_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      wr_en_r     <= 1'b0;
      frame_err_r <= 1'b0;
      case (state_r)
        // WRITE lasts one cycle and treats its byte like IDLE does.
        ST_IDLE, ST_WRITE: begin
          tmo_cnt_r <= CNT_ZERO;
          if (is_sync_s) begin
            state_r <= ST_ADDR;
            busy_r  <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        // Any byte here is an address, including SYNC_BYTE.
        ST_ADDR: begin
          if (bus.rcv) begin
            addr_r    <= bus.rx_data;
            tmo_cnt_r <= CNT_ZERO;
            state_r   <= ST_DATA;
          end else if (tmo_hit_s) begin
            frame_err_r <= 1'b1;
            tmo_cnt_r   <= CNT_ZERO;
            state_r     <= ST_IDLE;
            busy_r      <= 1'b0;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + CNT_ONE;
          end
        end
        ST_DATA: begin
          if (bus.rcv) begin
            tmo_cnt_r <= CNT_ZERO;
`ifdef FRAME_CHK_EN
            data_r    <= bus.rx_data;
            state_r   <= ST_CHK;
`else
            wr_en_r   <= 1'b1;
            wr_addr_r <= addr_r;
            wr_data_r <= bus.rx_data;
            state_r   <= ST_WRITE;
`endif
          end else if (tmo_hit_s) begin
            frame_err_r <= 1'b1;
            tmo_cnt_r   <= CNT_ZERO;
            state_r     <= ST_IDLE;
            busy_r      <= 1'b0;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + CNT_ONE;
          end
        end
`ifdef FRAME_CHK_EN
        ST_CHK: begin
          if (bus.rcv) begin
            tmo_cnt_r <= CNT_ZERO;
            if (bus.rx_data == frame_sum(addr_r, data_r)) begin
              wr_en_r   <= 1'b1;
              wr_addr_r <= addr_r;
              wr_data_r <= data_r;
              state_r   <= ST_WRITE;
            end else begin
              frame_err_r <= 1'b1;
              state_r     <= ST_IDLE;
              busy_r      <= 1'b0;
            end
          end else if (tmo_hit_s) begin
            frame_err_r <= 1'b1;
            tmo_cnt_r   <= CNT_ZERO;
            state_r     <= ST_IDLE;
            busy_r      <= 1'b0;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + CNT_ONE;
          end
        end
`endif
        default: begin
          tmo_cnt_r <= CNT_ZERO;
          state_r   <= ST_IDLE;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.wr_en     = wr_en_r;
  assign bus.wr_addr   = wr_addr_r;
  assign bus.wr_data   = wr_data_r;
  assign bus.frame_err = frame_err_r;
  assign bus.busy      = busy_r;

endmodule
